chi_rx_link_ctrl: RTL and testbench

//  Receive-side CHI link layer for one channel (REQ/RSP/DAT), upstream of the Home Node controller.

---
 rtl/chi_rx_link_ctrl_pkg.sv | 15 +
 rtl/chi_rx_link_ctrl_flit_fifo.sv | 57 +++++
 rtl/chi_rx_link_ctrl.sv | 156 +++++++++++++++
 tb/tb_chi_rx_link_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/chi_rx_link_ctrl_pkg.sv
// Shared types and constants for the CHI receive-side link controller.
package chi_rx_link_ctrl_pkg;

   typedef enum logic [1:0] {
      StStop,
      StActivate,
      StRun,
      StDeactivate
   } link_state_t;

   // Opcode value 0 on every channel marks a returned L-credit, not a real transaction.
   localparam int unsigned LCRD_RETURN  = 0;
   localparam int unsigned MAX_LCRD_CHI = 15;

endpackage

// File: rtl/chi_rx_link_ctrl_flit_fifo.sv
// Synchronous flit FIFO. Head is read straight from storage, so a pushed flit is visible on dout
// the cycle after the write and holds steady until popped.
module chi_rx_link_ctrl_flit_fifo #(
   parameter int unsigned W     = 72,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   // Qualify requests: pop on empty is ignored; push on full only lands if a pop frees a slot.
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      count   = count_q;
      dout    = empty ? '0 : mem_q[rd_ptr_q];
   end

   // Storage array; no reset needed since dout is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/chi_rx_link_ctrl.sv
// CHI receive link layer for one channel: link activation FSM, L-credit issue, credit-return
// filtering and a credit-protected flit FIFO feeding the HN controller.
module chi_rx_link_ctrl
   import chi_rx_link_ctrl_pkg::*;
#(
   parameter int unsigned FLIT_W   = 72,
   parameter int unsigned OPC_LSB  = 0,
   parameter int unsigned OPC_W    = 7,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_LCRD = MAX_LCRD_CHI
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              linkactivereq_i,
   output logic              linkactiveack_o,
   input  logic              flitpend_i,
   input  logic              flitv_i,
   input  logic [FLIT_W-1:0] flit_i,
   output logic              lcrdv_o,
   output logic [FLIT_W-1:0] flit_o,
   output logic              flit_valid_o,
   input  logic              flit_ready_i,
   output logic              flit_pend_o,
   output logic              crd_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_LCRD + 1);
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = ((CNT_W > CW) ? CNT_W : CW) + 1;

   link_state_t      state_q;
   logic             ack_q;
   logic             lcrdv_q;
   logic             pend_q;
   logic             err_q;
   logic [CNT_W-1:0] crd_cnt_q;
   logic [CNT_W-1:0] crd_cnt_d;
   logic [CNT_W-1:0] crd_after;
   logic [SUM_W-1:0] total;

   logic             is_lcrd_ret;
   logic             consume;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             overflow_drop;
   logic             issue_window;
   logic             issue;

   logic [FLIT_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CW-1:0]     fifo_count;

   // Flit acceptance, routing and the credit-issue decision for this cycle.
   always_comb begin
      is_lcrd_ret   = (flit_i[OPC_LSB +: OPC_W] == OPC_W'(LCRD_RETURN));
      consume       = flitv_i && (crd_cnt_q != '0);
      push_req      = consume && !is_lcrd_ret;
      pop           = !fifo_empty && flit_ready_i;
      push          = push_req && (!fifo_full || pop);
      overflow_drop = push_req && fifo_full && !pop;
      crd_after     = crd_cnt_q - CNT_W'(consume);
      // Credits still out plus flits parked after this cycle's push/pop must fit in the FIFO.
      total         = SUM_W'(crd_after) + SUM_W'(fifo_count) + SUM_W'(push) - SUM_W'(pop);
      // The pulse registered here is seen while the link sits in RUN.
      issue_window  = (state_q == StActivate) || ((state_q == StRun) && linkactivereq_i);
      issue         = issue_window && (total < SUM_W'(DEPTH)) &&
                      (crd_after < CNT_W'(MAX_LCRD));
      crd_cnt_d     = crd_after + CNT_W'(issue);
   end

   // Link activation FSM with registered ack and credit pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StStop;
         ack_q   <= 1'b0;
         lcrdv_q <= 1'b0;
      end else begin
         lcrdv_q <= issue;
         unique case (state_q)
            StStop: begin
               if (linkactivereq_i) state_q <= StActivate;
            end
            StActivate: begin
               state_q <= StRun;
               ack_q   <= 1'b1;
            end
            StRun: begin
               if (!linkactivereq_i) state_q <= StDeactivate;
            end
            StDeactivate: begin
               // Wait for every outstanding credit to come home, even if req re-asserts.
               if (crd_cnt_q == '0) begin
                  state_q <= StStop;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= StStop;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding credit counter held by the transmitter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         crd_cnt_q <= '0;
      end else begin
         crd_cnt_q <= crd_cnt_d;
      end
   end

   // Sticky protocol error: flit without a credit, or a flit that found the FIFO full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if ((flitv_i && (crd_cnt_q == '0)) || overflow_drop) begin
         err_q <= 1'b1;
      end
   end

   // Early flit indication delayed one cycle regardless of link state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= flitpend_i;
      end
   end

   chi_rx_link_ctrl_flit_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .din   (flit_i),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign linkactiveack_o = ack_q;
   assign lcrdv_o         = lcrdv_q;
   assign flit_o          = fifo_dout;
   assign flit_valid_o    = !fifo_empty;
   assign flit_pend_o     = pend_q;
   assign crd_err_o       = err_q;

endmodule

// File: tb/tb_chi_rx_link_ctrl.sv
// Directed bench for chi_rx_link_ctrl: bring-up, throughput, backpressure, credit return,
// credit error and reset mid-run, with hand-computed expectations.
module tb_chi_rx_link_ctrl;

   localparam int unsigned FLIT_W = 72;

   logic              clk = 1'b0;
   logic              rstn;
   logic              linkactivereq_i;
   logic              linkactiveack_o;
   logic              flitpend_i;
   logic              flitv_i;
   logic [FLIT_W-1:0] flit_i;
   logic              lcrdv_o;
   logic [FLIT_W-1:0] flit_o;
   logic              flit_valid_o;
   logic              flit_ready_i;
   logic              flit_pend_o;
   logic              crd_err_o;

   int n_tests  = 0;
   int n_fail   = 0;
   int held     = 0;
   int max_held = 0;
   int pulses   = 0;

   always #5 clk = ~clk;

   chi_rx_link_ctrl #(
      .FLIT_W   (FLIT_W),
      .OPC_LSB  (0),
      .OPC_W    (7),
      .DEPTH    (4),
      .MAX_LCRD (15)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .linkactivereq_i (linkactivereq_i),
      .linkactiveack_o (linkactiveack_o),
      .flitpend_i      (flitpend_i),
      .flitv_i         (flitv_i),
      .flit_i          (flit_i),
      .lcrdv_o         (lcrdv_o),
      .flit_o          (flit_o),
      .flit_valid_o    (flit_valid_o),
      .flit_ready_i    (flit_ready_i),
      .flit_pend_o     (flit_pend_o),
      .crd_err_o       (crd_err_o)
   );

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] mk(input logic [6:0] opc, input logic [63:0] payload);
      return {1'b0, payload, opc};
   endfunction

   // One clock; outputs sampled 1 time unit after the edge. Tracks credits seen on lcrdv_o.
   task automatic step();
      if (flitv_i && held > 0) held--;
      @(posedge clk);
      #1;
      if (lcrdv_o) held++;
      if (held > max_held) max_held = held;
   endtask

   initial begin
      rstn            = 1'b0;
      linkactivereq_i = 1'b0;
      flitpend_i      = 1'b0;
      flitv_i         = 1'b0;
      flit_i          = '0;
      flit_ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check_eq("rst_ack",   72'(linkactiveack_o), 72'(0));
      check_eq("rst_lcrdv", 72'(lcrdv_o),         72'(0));
      check_eq("rst_valid", 72'(flit_valid_o),    72'(0));
      check_eq("rst_flit",  flit_o,               72'(0));
      check_eq("rst_pend",  72'(flit_pend_o),     72'(0));
      check_eq("rst_err",   72'(crd_err_o),       72'(0));

      rstn = 1'b1;
      // flit_pend_o follows flitpend_i one cycle later while the link is down
      flitpend_i = 1'b1;
      step();
      check_eq("pend_rise", 72'(flit_pend_o), 72'(1));
      flitpend_i = 1'b0;
      step();
      check_eq("pend_fall", 72'(flit_pend_o), 72'(0));
      check_eq("stop_ack",  72'(linkactiveack_o), 72'(0));

      // 1 Bring-up: req at cycle 0 -> ack at cycle 2, four consecutive credit pulses
      linkactivereq_i = 1'b1;
      step();
      check_eq("ack_c1", 72'(linkactiveack_o), 72'(0));
      step();
      check_eq("ack_c2", 72'(linkactiveack_o), 72'(1));
      for (int i = 0; i < 6; i++) begin
         check_eq("bringup_lcrdv", 72'(lcrdv_o), 72'(i < 4));
         step();
      end

      // 2 Throughput: back-to-back opcode 0x01, ready high
      flit_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         flitv_i = 1'b1;
         flit_i  = mk(7'h01, 64'h0A0 + 64'(i));
         step();
         check_eq("tp_valid", 72'(flit_valid_o), 72'(1));
         check_eq("tp_flit",  flit_o, mk(7'h01, 64'h0A0 + 64'(i)));
         check_eq("tp_lcrdv", 72'(lcrdv_o), 72'(i != 0));
      end
      flitv_i = 1'b0;
      step();
      check_eq("tp_drain_valid", 72'(flit_valid_o), 72'(0));
      check_eq("tp_last_lcrdv",  72'(lcrdv_o), 72'(1));
      step();
      check_eq("tp_idle_lcrdv",  72'(lcrdv_o), 72'(0));
      check_eq("tp_max_credits", 72'(max_held), 72'(4));

      // 3 Backpressure: ready low, fill the FIFO
      flit_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         flitv_i = 1'b1;
         flit_i  = mk(7'h22, 64'h0B0 + 64'(i));
         step();
         check_eq("bp_head",  flit_o, mk(7'h22, 64'h0B0));
         check_eq("bp_lcrdv", 72'(lcrdv_o), 72'(0));
      end
      flitv_i = 1'b0;
      repeat (2) begin
         step();
         check_eq("bp_hold_flit",  flit_o, mk(7'h22, 64'h0B0));
         check_eq("bp_hold_valid", 72'(flit_valid_o), 72'(1));
         check_eq("bp_hold_lcrdv", 72'(lcrdv_o), 72'(0));
      end
      flit_ready_i = 1'b1;
      for (int i = 1; i < 4; i++) begin
         step();
         check_eq("bp_order", flit_o, mk(7'h22, 64'h0B0 + 64'(i)));
         check_eq("bp_resume_lcrdv", 72'(lcrdv_o), 72'(1));
      end
      step();
      check_eq("bp_empty", 72'(flit_valid_o), 72'(0));
      check_eq("bp_last_lcrdv", 72'(lcrdv_o), 72'(1));
      step();
      check_eq("bp_idle_lcrdv", 72'(lcrdv_o), 72'(0));
      check_eq("bp_max_credits", 72'(max_held), 72'(4));

      // 4 Credit return: drop req while returning one credit, leaving 3 held
      flitv_i         = 1'b1;
      flit_i          = mk(7'h00, 64'h0C0);
      linkactivereq_i = 1'b0;
      step();
      check_eq("deact_ack",   72'(linkactiveack_o), 72'(1));
      check_eq("deact_lcrdv", 72'(lcrdv_o), 72'(0));
      check_eq("deact_held",  72'(held), 72'(3));
      for (int i = 0; i < 3; i++) begin
         flit_i = mk(7'h00, 64'h0C1 + 64'(i));
         step();
         check_eq("ret_no_flit", 72'(flit_valid_o), 72'(0));
         check_eq("ret_ack",     72'(linkactiveack_o), 72'(1));
         check_eq("ret_lcrdv",   72'(lcrdv_o), 72'(0));
      end
      flitv_i = 1'b0;
      step();
      check_eq("ack_drop", 72'(linkactiveack_o), 72'(0));
      check_eq("ret_err",  72'(crd_err_o), 72'(0));

      // 5 Error: flit with no credits held
      flitv_i = 1'b1;
      flit_i  = mk(7'h01, 64'h0D0);
      step();
      check_eq("err_set",   72'(crd_err_o), 72'(1));
      check_eq("err_drop",  72'(flit_valid_o), 72'(0));
      flitv_i = 1'b0;
      repeat (2) step();
      check_eq("err_sticky", 72'(crd_err_o), 72'(1));
      check_eq("err_fifo",   72'(flit_valid_o), 72'(0));

      // 6 Reset mid-run with two flits buffered
      linkactivereq_i = 1'b1;
      flit_ready_i    = 1'b0;
      step();
      step();
      check_eq("rerun_ack", 72'(linkactiveack_o), 72'(1));
      repeat (3) step();
      flitv_i = 1'b1;
      flit_i  = mk(7'h03, 64'h0E0);
      step();
      flit_i  = mk(7'h03, 64'h0E1);
      step();
      flitv_i = 1'b0;
      step();
      check_eq("mid_valid", 72'(flit_valid_o), 72'(1));
      check_eq("mid_flit",  flit_o, mk(7'h03, 64'h0E0));
      #2;
      rstn = 1'b0;
      #1;
      check_eq("arst_valid", 72'(flit_valid_o), 72'(0));
      check_eq("arst_ack",   72'(linkactiveack_o), 72'(0));
      check_eq("arst_flit",  flit_o, 72'(0));
      check_eq("arst_err",   72'(crd_err_o), 72'(0));
      check_eq("arst_lcrdv", 72'(lcrdv_o), 72'(0));
      held   = 0;
      pulses = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (lcrdv_o) pulses++;
      end
      check_eq("rehs_credits", 72'(pulses), 72'(4));
      check_eq("rehs_ack",     72'(linkactiveack_o), 72'(1));
      check_eq("rehs_valid",   72'(flit_valid_o), 72'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
